// File: rtl/lfsr_counter_multi.sv
// rtl/lfsr_counter_multi.sv - Fibonacci LFSR counter with terminal-count modes and lockup recovery
module lfsr_counter_multi #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = 4'b1001,
    parameter logic [WIDTH-1:0] SEED = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cen,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] count_to,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic [WIDTH-1:0] steps,
    output logic             lockup_err
);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] lfsr_next;
    logic             advance;

    assign lfsr_next = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    assign advance   = cen && !load && !done_q;

    always_comb begin
        q_d      = q_q;
        reload_d = reload_q;
        steps_d  = steps_q;
        tc_d     = 1'b0;
        done_d   = done_q;
        lockup_d = lockup_q;
        if (load) begin
            q_d      = data;
            reload_d = data;
            steps_d  = ZERO;
            done_d   = 1'b0;
            if (data != ZERO) begin
                lockup_d = 1'b0;
            end
        end else if (advance) begin
            if (q_q == ZERO) begin
                // All-zero is a dead state for an XOR LFSR; reseed and flag it.
                q_d      = SEED;
                lockup_d = 1'b1;
                steps_d  = steps_q + ONE;
            end else if (q_q == count_to) begin
                tc_d = 1'b1;
                case (mode)
                    2'b01: begin
                        q_d     = reload_q;
                        steps_d = ZERO;
                    end
                    2'b10: begin
                        done_d = 1'b1;
                    end
                    default: begin
                        q_d     = lfsr_next;
                        steps_d = steps_q + ONE;
                    end
                endcase
            end else begin
                q_d     = lfsr_next;
                steps_d = steps_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q      <= SEED;
            reload_q <= SEED;
            steps_q  <= ZERO;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            reload_q <= reload_d;
            steps_q  <= steps_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
            lockup_q <= lockup_d;
        end
    end

    assign q          = q_q;
    assign tc         = tc_q;
    assign done       = done_q;
    assign steps      = steps_q;
    assign lockup_err = lockup_q;
endmodule
